// File: rtl/queue_drain_pkg.sv
// Shared types and defaults for the two-channel queue drain/merge block.
package queue_drain_pkg;

  // Channel identifier; the value doubles as the tag bit on merged words.
  typedef enum logic {
    CH_A = 1'b0,
    CH_B = 1'b1
  } channel_e;

  localparam int unsigned DEF_D_WIDTH   = 6;
  localparam int unsigned DEF_CNT_WIDTH = 8;

  // The channel that is not `ch`; used to alternate service on a tie.
  function automatic channel_e other_ch(input channel_e ch);
    channel_e res;
    case (ch)
      CH_A:    res = CH_B;
      CH_B:    res = CH_A;
      default: res = CH_A;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/queue_drain_if.sv
// Bundle of the queue-side and downstream-side signals of queue_drain.
// master: the drain block (pops queues, drives merged word).
// slave:  the surrounding queues and downstream consumer.
interface queue_drain_if
  import queue_drain_pkg::*;
#(
  parameter int unsigned D_WIDTH = DEF_D_WIDTH
) ();

  logic [D_WIDTH-1:0] down_data_a;
  logic [D_WIDTH-1:0] down_data_b;
  logic               empty_a;
  logic               empty_b;
  logic               pop_a;
  logic               pop_b;
  logic [D_WIDTH:0]   out_data;
  logic               out_valid;
  logic               out_ready;

  modport master (
    input  down_data_a,
    input  down_data_b,
    input  empty_a,
    input  empty_b,
    output pop_a,
    output pop_b,
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    output down_data_a,
    output down_data_b,
    output empty_a,
    output empty_b,
    input  pop_a,
    input  pop_b,
    input  out_data,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/queue_drain_rr_arb2.sv
// Two-request round-robin arbiter, purely combinational.
// grant[0] = channel A, grant[1] = channel B; at most one bit set.
module rr_arb2
  import queue_drain_pkg::*;
(
  input  logic       req_a,
  input  logic       req_b,
  input  channel_e   last_grant,
  output logic [1:0] grant
);

  // Serve a lone requester; on a tie serve the channel that did not win last.
  always_comb begin
    grant = 2'b00;
    case ({req_b, req_a})
      2'b00: grant = 2'b00;
      2'b01: grant = 2'b01;
      2'b10: grant = 2'b10;
      2'b11: begin
        if (other_ch(last_grant) == CH_A) begin
          grant = 2'b01;
        end else begin
          grant = 2'b10;
        end
      end
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/queue_drain.sv
// Drains two first-word-fall-through queues into one tagged output stream,
// alternating strictly between channels when both hold data, and counts
// the words taken from each channel.
module queue_drain
  import queue_drain_pkg::*;
#(
  parameter int unsigned D_WIDTH   = DEF_D_WIDTH,
  parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  queue_drain_if.master        bus,
  output logic [CNT_WIDTH-1:0] drained_a,
  output logic [CNT_WIDTH-1:0] drained_b
);

  logic                 load_en_s;
  logic [1:0]           grant_s;
  logic                 pop_a_s;
  logic                 pop_b_s;
  channel_e             last_grant_r;
  channel_e             last_grant_nxt_s;
  logic                 out_valid_r;
  logic [D_WIDTH:0]     out_data_r;
  logic [CNT_WIDTH-1:0] drained_a_r;
  logic [CNT_WIDTH-1:0] drained_b_r;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // The output slot can take a word when it is empty or being consumed now.
  assign load_en_s = !out_valid_r || bus.out_ready;

  rr_arb2 u_arb (
    .req_a      (!bus.empty_a),
    .req_b      (!bus.empty_b),
    .last_grant (last_grant_r),
    .grant      (grant_s)
  );

  // Pops are gated by reset so nothing leaves a queue while the block is held.
  assign pop_a_s = !rst && load_en_s && grant_s[0];
  assign pop_b_s = !rst && load_en_s && grant_s[1];

  assign bus.pop_a     = pop_a_s;
  assign bus.pop_b     = pop_b_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign drained_a     = drained_a_r;
  assign drained_b     = drained_b_r;

  // Round-robin pointer next state: it only moves when a word is actually popped.
  always_comb begin
    last_grant_nxt_s = last_grant_r;
    if (pop_a_s) begin
      last_grant_nxt_s = CH_A;
    end else if (pop_b_s) begin
      last_grant_nxt_s = CH_B;
    end else begin
      last_grant_nxt_s = last_grant_r;
    end
  end

  // Round-robin pointer register; reset to B so A wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_r <= CH_B;
    end else begin
      last_grant_r <= last_grant_nxt_s;
    end
  end

  // Output word register: load the popped head with its tag, empty the slot when
  // the word is consumed and nothing replaces it, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {(D_WIDTH+1){1'b0}};
    end else if (load_en_s) begin
      if (pop_a_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= {1'b0, bus.down_data_a};
      end else if (pop_b_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= {1'b1, bus.down_data_b};
      end else begin
        out_valid_r <= 1'b0;
      end
    end
  end

  // Per-channel drained-word counters; they wrap naturally at full scale.
  always_ff @(posedge clk) begin
    if (rst) begin
      drained_a_r <= {CNT_WIDTH{1'b0}};
      drained_b_r <= {CNT_WIDTH{1'b0}};
    end else begin
      if (pop_a_s) begin
        drained_a_r <= drained_a_r + CNT_ONE;
      end
      if (pop_b_s) begin
        drained_b_r <= drained_b_r + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_queue_drain.sv
// Self-checking bench for queue_drain: directed scenarios with literal
// expectations plus a randomized phase, all checked each cycle against a
// queue-based behavioural model.
module tb_queue_drain;

  localparam int DW = 6;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] drained_a;
  logic [CW-1:0] drained_b;

  queue_drain_if #(.D_WIDTH(DW)) bus ();

  queue_drain #(.D_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .drained_a (drained_a),
    .drained_b (drained_b)
  );

  always #5 clk = ~clk;

  // Queue contents seen by the DUT and log of words accepted downstream.
  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];
  logic [DW:0]   acc_log[$];

  int   vectors     = 0;
  int   miscompares = 0;
  bit   chk_en      = 1'b0;
  logic rst_v       = 1'b1;
  logic ready_v     = 1'b1;

  // Behavioural model state.
  bit          m_valid = 1'b0;
  logic [DW:0] m_data  = '0;
  int          m_cnt_a = 0;
  int          m_cnt_b = 0;
  int          m_last  = 1;   // 0 = A served last, 1 = B served last
  bit          exp_pop_a = 1'b0;
  bit          exp_pop_b = 1'b0;
  logic        last_pop_a;
  logic        last_pop_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %0h, required %0h", name, act, exp);
    end
  endtask

  // Compare process: derive the expected pops from the model and compare all outputs.
  always @(negedge clk) begin : compare
    bit na, nb, load;
    na = (qa.size() != 0);
    nb = (qb.size() != 0);
    load = !m_valid || ready_v;
    exp_pop_a = !rst_v && load && na && (!nb || m_last == 1);
    exp_pop_b = !rst_v && load && nb && (!na || m_last == 0);
    if (chk_en) begin
      chk("pop_a", bus.pop_a, exp_pop_a);
      chk("pop_b", bus.pop_b, exp_pop_b);
      chk("out_valid", bus.out_valid, m_valid);
      if (m_valid) chk("out_data", bus.out_data, m_data);
      chk("drained_a", drained_a, m_cnt_a % (1 << CW));
      chk("drained_b", drained_b, m_cnt_b % (1 << CW));
    end
  end

  // One clock cycle: drive inputs, observe pops, advance the model at the edge.
  task automatic step();
    rst             = rst_v;
    bus.out_ready   = ready_v;
    bus.empty_a     = (qa.size() == 0);
    bus.empty_b     = (qb.size() == 0);
    bus.down_data_a = (qa.size() != 0) ? qa[0] : {DW{1'b0}};
    bus.down_data_b = (qb.size() != 0) ? qb[0] : {DW{1'b0}};
    @(negedge clk);
    last_pop_a = bus.pop_a;
    last_pop_b = bus.pop_b;
    @(posedge clk);
    if (rst_v) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_cnt_a = 0;
      m_cnt_b = 0;
      m_last  = 1;
    end else begin
      if (m_valid && ready_v) acc_log.push_back(m_data);
      if (exp_pop_a) begin
        m_data  = {1'b0, qa.pop_front()};
        m_valid = 1'b1;
        m_cnt_a++;
        m_last  = 0;
      end else if (exp_pop_b) begin
        m_data  = {1'b1, qb.pop_front()};
        m_valid = 1'b1;
        m_cnt_b++;
        m_last  = 1;
      end else if (!m_valid || ready_v) begin
        m_valid = 1'b0;
      end
    end
    #1;
  endtask

  logic [DW:0] rr_exp [6];

  initial begin
    rr_exp = '{7'h01, 7'h44, 7'h02, 7'h45, 7'h03, 7'h46};

    // Reset state.
    rst_v = 1'b1; ready_v = 1'b1;
    step();
    chk_en = 1'b1;
    step();
    chk("rst out_valid", bus.out_valid, 32'd0);
    chk("rst out_data", bus.out_data, 32'd0);
    chk("rst drained_a", drained_a, 32'd0);
    chk("rst drained_b", drained_b, 32'd0);

    // Single A word, first pop right after reset release.
    qa.push_back(6'h05);
    rst_v = 1'b0;
    step();
    chk("single pop_a", last_pop_a, 32'd1);
    chk("single pop_b", last_pop_b, 32'd0);
    chk("single out_valid", bus.out_valid, 32'd1);
    chk("single out_data", bus.out_data, 32'h05);
    chk("single drained_a", drained_a, 32'd1);

    // Strict alternation when both channels hold data.
    rst_v = 1'b1;
    qa.push_back(6'd1); qa.push_back(6'd2); qa.push_back(6'd3);
    qb.push_back(6'd4); qb.push_back(6'd5); qb.push_back(6'd6);
    step();
    rst_v = 1'b0;
    acc_log.delete();
    for (int i = 0; i < 20 && (qa.size() != 0 || qb.size() != 0 || m_valid); i++) step();
    chk("rr log size", acc_log.size(), 32'd6);
    for (int i = 0; i < 6 && i < acc_log.size(); i++) chk("rr order", acc_log[i], rr_exp[i]);
    chk("rr drained_a", drained_a, 32'd3);
    chk("rr drained_b", drained_b, 32'd3);

    // Backpressure: B word held stable, no pops, then A loaded on release.
    rst_v = 1'b1; ready_v = 1'b0;
    qb.push_back(6'h2A);
    step();
    rst_v = 1'b0;
    step();
    chk("hold pop_b", last_pop_b, 32'd1);
    qa.push_back(6'h11);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold data", bus.out_data, 32'h6A);
      chk("hold pops", {last_pop_a, last_pop_b}, 32'd0);
    end
    ready_v = 1'b1;
    step();
    chk("release pop_a", last_pop_a, 32'd1);
    chk("release data", bus.out_data, 32'h11);

    // Both queues empty while the held word is consumed.
    chk("empty pre valid", bus.out_valid, 32'd1);
    step();
    chk("empty pops", {last_pop_a, last_pop_b}, 32'd0);
    chk("empty out_valid", bus.out_valid, 32'd0);

    // Counter wrap.
    rst_v = 1'b1;
    step();
    rst_v = 1'b0;
    for (int i = 0; i < 255; i++) qa.push_back(6'($urandom));
    for (int i = 0; i < 300 && qa.size() != 0; i++) step();
    chk("wrap 255", drained_a, 32'd255);
    qa.push_back(6'h3F); qa.push_back(6'h00);
    step();
    chk("wrap 0", drained_a, 32'd0);
    step();
    chk("wrap 1", drained_a, 32'd1);
    step(); step();

    // Reset mid-transfer.
    rst_v = 1'b1;
    step();
    rst_v = 1'b0; ready_v = 1'b0;
    qa.push_back(6'h0A); qa.push_back(6'h0B); qa.push_back(6'h0C);
    qb.push_back(6'h1A); qb.push_back(6'h1B); qb.push_back(6'h1C);
    step(); step();
    chk("pre-rst valid", bus.out_valid, 32'd1);
    rst_v = 1'b1;
    step();
    chk("rst pops", {last_pop_a, last_pop_b}, 32'd0);
    chk("mid-rst out_valid", bus.out_valid, 32'd0);
    chk("mid-rst out_data", bus.out_data, 32'd0);
    chk("mid-rst drained_a", drained_a, 32'd0);
    chk("mid-rst drained_b", drained_b, 32'd0);
    rst_v = 1'b0; ready_v = 1'b1;
    step();
    chk("post-rst pop_a", last_pop_a, 32'd1);
    chk("post-rst pop_b", last_pop_b, 32'd0);

    // Randomized traffic, backpressure and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      if (qa.size() < 8 && $urandom_range(0, 2) == 0) qa.push_back(6'($urandom));
      if (qb.size() < 8 && $urandom_range(0, 2) == 0) qb.push_back(6'($urandom));
      ready_v = ($urandom_range(0, 3) != 0);
      rst_v   = ($urandom_range(0, 199) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/queue_drain.md
QUEUE_DRAIN -- requirements
Module: queue_drain

Interface
REQ-001 Parameter D_WIDTH, default 6: width of each channel data word.
REQ-002 Parameter CNT_WIDTH, default 8: width of per-channel drained-word counters.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 down_data_a  input  D_WIDTH  channel A queue head word, valid whenever empty_a is low (first-word-fall-through).
REQ-006 down_data_b  input  D_WIDTH  channel B queue head word, valid whenever empty_b is low.
REQ-007 empty_a  input  1  channel A queue empty.
REQ-008 empty_b  input  1  channel B queue empty.
REQ-009 pop_a  output  1  remove channel A head at this posedge.
REQ-010 pop_b  output  1  remove channel B head at this posedge.
REQ-011 out_data  output  D_WIDTH+1  merged word; MSB = channel tag (0=A, 1=B), LSBs = data.
REQ-012 out_valid  output  1  out_data holds a word.
REQ-013 out_ready  input  1  downstream accepts out_data when out_valid and out_ready are both high.
REQ-014 drained_a, drained_b  output  CNT_WIDTH each  count of words popped per channel.

Function
REQ-015 load_en = !out_valid || out_ready; a new word is taken only when load_en is high.
REQ-016 Grant is combinational from empty_a, empty_b and last_grant; pop_x = load_en && grant_x; at most one pop per cycle.
REQ-017 Only A non-empty -> grant A; only B non-empty -> grant B; both empty -> no grant, no pop.
REQ-018 Both non-empty -> grant the channel not equal to last_grant (strict round-robin).
REQ-019 last_grant updates to the granted channel only in cycles where a pop is issued.
REQ-020 On a pop, out_data <= {tag, granted head} and out_valid <= 1 at the same posedge; latency 1 cycle from pop to out_valid.
REQ-021 load_en high with no grant -> out_valid <= 0 (word consumed, nothing replaces it).
REQ-022 out_valid high and out_ready low -> out_data, out_valid held stable; pop_a = pop_b = 0.
REQ-023 Sustained throughput: one word per cycle while out_ready is high and any channel is non-empty.
REQ-024 drained_x increments by 1 on each cycle pop_x is high; wraps modulo 2^CNT_WIDTH.
REQ-025 pop_x never asserts while empty_x is high.

Reset
REQ-026 While rst high: pop_a = pop_b = 0 (combinationally gated), out_valid = 0, out_data = 0, drained_a = drained_b = 0, last_grant = B (so A wins first tie).
REQ-027 Reset mid-transfer discards any held out_data word; no pop issued in any cycle rst is high.
REQ-028 First pop possible in the first cycle after rst deasserts.

Structure
REQ-029 Package queue_drain_pkg holds: channel enum (CH_A=0, CH_B=1), default D_WIDTH and CNT_WIDTH constants.
REQ-030 Sub-module rr_arb2 (two requests, last_grant in, one-hot grant out, purely combinational); counters, last_grant and the output register reside in queue_drain.

Verification
REQ-031 Reset then A holds 0x05, B empty, out_ready=1 -> pop_a in cycle 1; cycle 2 out_valid=1, out_data=0x05 (tag 0), drained_a=1.
REQ-032 A holds {1,2,3} and B holds {4,5,6}, out_ready=1 -> outputs A1,B4,A2,B5,A3,B6 on consecutive cycles; drained_a=drained_b=3.
REQ-033 Word 0x2A from B held with out_ready=0 for 5 cycles, A non-empty -> out_data=0x6A stable, no pops; out_ready=1 -> A head loaded next cycle.
REQ-034 255 A words then 2 more -> drained_a reads 255 then wraps to 0 then 1.
REQ-035 rst asserted while out_valid=1 and both queues non-empty -> next cycle out_valid=0, counters 0, no pops during rst; after release A popped first.
REQ-036 Both queues empty, out_valid=1, out_ready=1 -> next cycle out_valid=0, no pops.
